// File: rtl/scoreboard_warp_gen.sv
// ----------------------------------------------------------------------------
// scoreboard_warp_gen
//
// Per-warp scoreboard with a parametrised number of entries. It tracks
// in-flight instructions and flags RAW/WAW/WAR hazards for the candidate
// instruction at the head of the instruction buffer.
//
// Parameters:
//   NUM_ENTRIES  slots per warp (>= 2)
//   ID_W         ScbID width
//   REG_W        register ID width
//   NUM_CLR      number of independent clear channels
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   src1, src2, dst (+ *_valid)       candidate instruction operands
//   issue_grant                       allocate a slot for the candidate
//   clr_id, clr_valid                 flattened clear IDs + per-channel strobes
//   rd_id, rd_valid                   operand-read release (optional feature)
//   full                              no free slot after this cycle's clears
//   dependent                         candidate hazards with a live entry
//   scb_id                            slot the candidate would be given
//   occupancy                         registered count of valid entries
//   err                               sticky protocol-error flag
//
// Optional feature macro: SCB_WAR_RELEASE_EN
//   When defined, rd_valid drops the source-valid bits of entry rd_id so WAR
//   hazards against it vanish before writeback. When undefined, rd_id and
//   rd_valid are ignored entirely.
// ----------------------------------------------------------------------------
module scoreboard_warp_gen #(
    parameter int NUM_ENTRIES = 4,
    parameter int ID_W        = $clog2(NUM_ENTRIES),
    parameter int REG_W       = 5,
    parameter int NUM_CLR     = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_W-1:0]        src1,
    input  logic [REG_W-1:0]        src2,
    input  logic [REG_W-1:0]        dst,
    input  logic                    src1_valid,
    input  logic                    src2_valid,
    input  logic                    dst_valid,
    input  logic                    issue_grant,
    input  logic [NUM_CLR*ID_W-1:0] clr_id,
    input  logic [NUM_CLR-1:0]      clr_valid,
    input  logic [ID_W-1:0]         rd_id,
    input  logic                    rd_valid,
    output logic                    full,
    output logic                    dependent,
    output logic [ID_W-1:0]         scb_id,
    output logic [ID_W:0]           occupancy,
    output logic                    err
);

    // Entry state
    logic [NUM_ENTRIES-1:0] valid;
    logic [NUM_ENTRIES-1:0] src1_v;
    logic [NUM_ENTRIES-1:0] src2_v;
    logic [NUM_ENTRIES-1:0] dst_v;
    logic [REG_W-1:0]       src1_r [NUM_ENTRIES];
    logic [REG_W-1:0]       src2_r [NUM_ENTRIES];
    logic [REG_W-1:0]       dst_r  [NUM_ENTRIES];

    // Combinational working signals
    logic [NUM_ENTRIES-1:0] clr_mask;
    logic [NUM_CLR-1:0]     clr_hit;
    logic                   clr_err;
    logic [NUM_ENTRIES-1:0] valid_clr;
    logic                   alloc;
    logic [NUM_ENTRIES-1:0] alloc_mask;
    logic [NUM_ENTRIES-1:0] valid_nxt;
    logic [ID_W:0]          occ_nxt;
    logic [NUM_ENTRIES-1:0] hazard;
    logic [NUM_ENTRIES-1:0] rd_mask;
    logic                   rd_err;
    logic                   grant_err;

    // ------------------------------------------------------------------------
    // Clear decode. A channel whose ID does not name a currently valid entry
    // (including IDs beyond NUM_ENTRIES) is a protocol error. Two channels
    // naming the same valid entry both see it valid, so duplicates are benign.
    // ------------------------------------------------------------------------
    always_comb begin
        clr_mask = '0;
        clr_hit  = '0;
        clr_err  = 1'b0;
        for (int k = 0; k < NUM_CLR; k++) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (clr_valid[k] && (clr_id[k*ID_W +: ID_W] == ID_W'(e))) begin
                    clr_mask[e] = 1'b1;
                    clr_hit[k]  = clr_hit[k] | valid[e];
                end
            end
            if (clr_valid[k] && !clr_hit[k]) begin
                clr_err = 1'b1;
            end
        end
    end

    assign valid_clr = valid & ~clr_mask;
    assign full      = &valid_clr;
    assign alloc     = issue_grant & ~full;
    assign grant_err = issue_grant & full;

    // Lowest free slot after clears; scanning downward leaves the lowest hit.
    always_comb begin
        scb_id = '0;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            if (!valid_clr[e]) begin
                scb_id = ID_W'(e);
            end
        end
    end

    always_comb begin
        alloc_mask = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            alloc_mask[e] = alloc && (scb_id == ID_W'(e));
        end
    end

    assign valid_nxt = valid_clr | alloc_mask;

    always_comb begin
        occ_nxt = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            occ_nxt = occ_nxt + (ID_W+1)'(valid_nxt[e]);
        end
    end

    // ------------------------------------------------------------------------
    // Hazard detection against entries that survive this cycle's clears.
    // ------------------------------------------------------------------------
    always_comb begin
        hazard = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            hazard[e] = valid_clr[e] && (
                // RAW
                (dst_v[e] && src1_valid && (src1 == dst_r[e])) ||
                (dst_v[e] && src2_valid && (src2 == dst_r[e])) ||
                // WAW
                (dst_v[e] && dst_valid && (dst == dst_r[e])) ||
                // WAR
                (dst_valid && src1_v[e] && (dst == src1_r[e])) ||
                (dst_valid && src2_v[e] && (dst == src2_r[e])));
        end
    end

    assign dependent = |hazard;

    // ------------------------------------------------------------------------
    // Operand-read release
    // ------------------------------------------------------------------------
`ifdef SCB_WAR_RELEASE_EN
    logic rd_hit;

    always_comb begin
        rd_mask = '0;
        rd_hit  = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (rd_valid && (rd_id == ID_W'(e))) begin
                rd_hit     = rd_hit | valid[e];
                // A grant into the same slot installs fresh sources; it wins.
                rd_mask[e] = ~alloc_mask[e];
            end
        end
        rd_err = rd_valid & ~rd_hit;
    end
`else
    logic unused_rd;

    assign unused_rd = ^{rd_id, rd_valid};
    assign rd_mask   = '0;
    assign rd_err    = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            src1_v    <= '0;
            src2_v    <= '0;
            dst_v     <= '0;
            occupancy <= '0;
            err       <= 1'b0;
        end else begin
            valid     <= valid_nxt;
            occupancy <= occ_nxt;
            if (grant_err || clr_err || rd_err) begin
                err <= 1'b1;
            end
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (alloc_mask[e]) begin
                    src1_v[e] <= src1_valid;
                    src2_v[e] <= src2_valid;
                    dst_v[e]  <= dst_valid;
                end else if (rd_mask[e]) begin
                    src1_v[e] <= 1'b0;
                    src2_v[e] <= 1'b0;
                end
            end
        end
    end

    // Register IDs are only meaningful while their valid bits are set.
    always_ff @(posedge clk) begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (!rst && alloc_mask[e]) begin
                src1_r[e] <= src1;
                src2_r[e] <= src2;
                dst_r[e]  <= dst;
            end
        end
    end

endmodule

// File: doc/scoreboard_warp_gen.md
# scoreboard_warp_gen

Parametrised per-warp scoreboard, the successor of the fixed 4-entry warp scoreboard. It tracks up to NUM_ENTRIES in-flight instructions for one warp and flags RAW, WAW and WAR hazards for the instruction at the head of the instruction buffer. It accepts NUM_CLR independent clear channels (MEM, ALU, CDB, ...) and reports occupancy and protocol errors. An optional operand-read release lets WAR hazards drop as soon as the Operand Collector has read the sources, instead of waiting for writeback.

## Interface
Parameters:
- NUM_ENTRIES, 4: scoreboard slots per warp; must be at least 2.
- ID_W, $clog2(NUM_ENTRIES): width of a ScbID.
- REG_W, 5: register ID width.
- NUM_CLR, 3: number of clear channels; bit/slice 0 has no priority meaning.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- src1, src2, dst  in  REG_W each  register IDs of the candidate instruction.
- src1_valid, src2_valid, dst_valid  in  1 each  operand-present qualifiers.
- issue_grant  in  1  Issue Unit grants the candidate; allocate a slot.
- clr_id  in  NUM_CLR*ID_W  flattened clear IDs; channel k occupies [k*ID_W +: ID_W].
- clr_valid  in  NUM_CLR  per-channel clear strobe.
- rd_id  in  ID_W  ScbID whose operands the Operand Collector has finished reading.
- rd_valid  in  1  strobe for rd_id.
- full  out  1  no free slot after this cycle's clears.
- dependent  out  1  candidate hazards with a live entry.
- scb_id  out  ID_W  slot the candidate will get; goes to the Operand Collector.
- occupancy  out  ID_W+1  registered count of valid entries.
- err  out  1  sticky protocol-error flag.

## Operation
- Per-entry state: valid, src1/src2/dst IDs, and the src1/src2/dst valid bits.
- Clear bypass:
  - valid_clr = valid with every entry named by an asserted clr_valid channel zeroed.
  - full, scb_id and dependent are all computed from valid_clr in the same cycle.
- Allocation:
  - scb_id = lowest-index zero bit of valid_clr; 0 when full.
  - issue_grant with !full: the slot at scb_id gets valid=1 and captures all six operand fields.
- Hazards, per entry e, masked by valid_clr[e]:
  - RAW: a valid candidate source equals dst[e] with dst_valid[e] set.
  - WAW: dst_valid and dst == dst[e] with dst_valid[e] set.
  - WAR: dst_valid and dst equals a valid src1[e] or src2[e].
  - dependent = OR over all entries.
- Errors (err is set sticky and cleared only by rst):
  - issue_grant while full: the grant is ignored.
  - a clear naming an entry that is already invalid in the registered valid array.
  - rd_valid naming an invalid entry.
- Duplicate clear IDs in one cycle are legal and idempotent; they do not set err.
- occupancy = popcount of the next-state valid array, registered.

## Timing
- Reset values, at the first rising edge with rst=1:
  - all valid bits 0 and all operand valid bits 0.
  - occupancy=0, err=0.
  - full=0, dependent=0, scb_id=0 on the cycle following reset.
- Latency: a clear affects full, dependent and scb_id combinationally in the same cycle. An allocation is visible to hazard checks from the next cycle.
- Clear and grant in the same cycle on the same slot: the slot is freed and reallocated, so it ends valid with the new contents. occupancy is updated accordingly.
- Wrap: there is no FIFO ordering. Slots are reused lowest-first, so IDs need not be issued in sequence.
- rst asserted mid-operation discards all entries. Clears or grants in that cycle are ignored.
- Data arrays do not need reset; only valid bits, occupancy and err are reset.

## Configuration
- SCB_WAR_RELEASE_EN defined:
  - rd_valid clears the src1/src2 valid bits of entry rd_id at the next edge. WAR hazards against that entry vanish from the following cycle; RAW and WAW are held until the entry is cleared.
  - rd_valid together with a grant on the same slot: the grant wins.
- Undefined: rd_id and rd_valid are ignored, including the error check, and WAR is held until the entry is cleared.

## Test plan
- NUM_ENTRIES=4, four grants with dst=1,2,3,4 -> scb_id 0,1,2,3; occupancy=4 and full=1 in the cycle after the last grant. A fifth grant -> ignored, err=1.
- Entries full; clr_valid=3'b101 with clr_id={2,x,1} -> full=0 and scb_id=1 in the same cycle; a grant that cycle -> occupancy=3 next cycle.
- Entry 0 has dst=7; candidate src1=7 -> dependent=1. Same cycle, channel 2 clears ID 0 -> dependent=0.
- Entry 0 has src2=9; candidate dst=9 -> dependent=1. With SCB_WAR_RELEASE_EN, rd_valid with rd_id=0 -> dependent=0 one cycle later. Without the macro -> it stays 1 until the entry is cleared.
- Clear of ID 3 while entry 3 is invalid -> err=1 and stays 1; rst -> err=0, occupancy=0.
- NUM_ENTRIES=8, REG_W=6: fill all 8 slots, then clear ID 5 and grant in the same cycle -> slot 5 is reused, occupancy stays 8, err=0.
